// File: rtl/tile_load_pkg.sv
// Shared types and geometry for the GEMM tile loader.
// Beat/row widths are derived here so the top and the masker agree on them.
package tile_load_pkg;
  localparam int TILE  = 16;
  localparam int DW    = 128;
  localparam int EW    = 16;
  localparam int AW    = 32;
  localparam int EPB   = DW / EW;
  localparam int BEATS = TILE * EW / DW;
  localparam int RW    = $clog2(TILE);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TILE) + 1;

  // A tile row has to be a whole, non-zero number of beats.
  localparam int BEATS_OK = (BEATS >= 1 && BEATS * DW == TILE * EW) ? 1 : 0;

  typedef enum logic [2:0] {
    IDLE, A_CMD, A_DATA, B_CMD, B_DATA, WAIT_ACK, DONE
  } state_t;
endpackage

// File: rtl/tile_load_sequencer_beat_mask.sv
// Zeroes the elements of one read beat that fall past the valid tile columns.
module tile_beat_mask
  import tile_load_pkg::*;
(
  input  logic [CW-1:0] i_valid_cols,
  input  logic [BW-1:0] i_beat,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);
  always_comb begin
    o_data = '0;
    for (int e = 0; e < EPB; e++) begin
      if ((int'(i_beat) * EPB + e) < int'(i_valid_cols))
        o_data[e*EW +: EW] = i_data[e*EW +: EW];
    end
  end
endmodule

// File: rtl/tile_load_sequencer.sv
// Walks an m x k by k x n GEMM in TILE x TILE tiles (mt, nt, kt innermost),
// fetching A/B tile rows over DMA and handing each loaded pair to the PE array.
//
// state    | meaning
// IDLE     | waiting for start
// A_CMD    | issuing DMA read for current A row
// A_DATA   | writing A row beats (DMA data, or zeros past row m)
// B_CMD    | issuing DMA read for current B row
// B_DATA   | writing B row beats (DMA data, or zeros past row k)
// WAIT_ACK | tile pair loaded, waiting for PE array
// DONE     | one-cycle completion pulse
module tile_load_sequencer
  import tile_load_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] addr_base_a,
  input  logic [AW-1:0] addr_base_b,
  input  logic [AW-1:0] stride_a,
  input  logic [AW-1:0] stride_b,
  input  logic [15:0]   m,
  input  logic [15:0]   k,
  input  logic [15:0]   n,
  output logic          busy,
  output logic          done,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW-1:0] cmd_addr,
  output logic [7:0]    cmd_len,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  output logic          buf_wr_en,
  output logic          buf_sel,
  output logic [RW-1:0] buf_row,
  output logic [BW-1:0] buf_beat,
  output logic [DW-1:0] buf_data,
  output logic          tile_valid,
  output logic          tile_last_k,
  input  logic          tile_ack
);
  if (BEATS_OK == 0) begin : g_bad_cfg
    $error("tile_load_sequencer: TILE*EW must be a non-zero multiple of DW");
  end

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_base_a, r_base_b, r_stride_a, r_stride_b;
  logic [15:0]   r_m, r_k, r_n, r_mt, r_nt, r_kt;
  logic [RW-1:0] r_row;
  logic [BW-1:0] r_beat;

  logic          w_is_a, w_in_data, w_row_ok, w_nxt_ok, w_wr, w_row_end, w_last_row;
  logic [16:0]   w_a_idx, w_b_idx, w_kt_inc, w_nt_inc, w_mt_inc;
  logic          w_kt_wrap, w_nt_wrap, w_mt_wrap, w_start_ok;
  logic [AW-1:0] w_addr_a, w_addr_b;
  logic [15:0]   w_cols_left;
  logic [CW-1:0] w_cols;
  logic [DW-1:0] w_masked;

  assign w_is_a    = (r_state == A_CMD) || (r_state == A_DATA);
  assign w_in_data = (r_state == A_DATA) || (r_state == B_DATA);
  assign w_a_idx   = {1'b0, r_mt} + 17'(r_row);
  assign w_b_idx   = {1'b0, r_kt} + 17'(r_row);
  assign w_row_ok  = w_is_a ? (w_a_idx < {1'b0, r_m}) : (w_b_idx < {1'b0, r_k});
  assign w_nxt_ok  = w_is_a ? ((w_a_idx + 17'd1) < {1'b0, r_m})
                            : ((w_b_idx + 17'd1) < {1'b0, r_k});

  assign w_addr_a = r_base_a + AW'(w_a_idx) * r_stride_a + AW'(r_kt) * AW'(EW / 8);
  assign w_addr_b = r_base_b + AW'(w_b_idx) * r_stride_b + AW'(r_nt) * AW'(EW / 8);

  assign w_cols_left = w_is_a ? (r_k - r_kt) : (r_n - r_nt);
  assign w_cols      = (w_cols_left >= 16'(TILE)) ? CW'(TILE) : CW'(w_cols_left);

  // Out-of-range rows are zero-filled at one beat per cycle, no DMA involved.
  assign w_wr       = w_in_data && (w_row_ok ? rd_valid : 1'b1);
  assign w_row_end  = w_wr && (r_beat == BW'(BEATS - 1));
  assign w_last_row = (r_row == RW'(TILE - 1));

  assign w_kt_inc  = {1'b0, r_kt} + 17'(TILE);
  assign w_nt_inc  = {1'b0, r_nt} + 17'(TILE);
  assign w_mt_inc  = {1'b0, r_mt} + 17'(TILE);
  assign w_kt_wrap = w_kt_inc >= {1'b0, r_k};
  assign w_nt_wrap = w_nt_inc >= {1'b0, r_n};
  assign w_mt_wrap = w_mt_inc >= {1'b0, r_m};

  assign w_start_ok = (m != 16'd0) && (k != 16'd0) && (n != 16'd0);

  tile_beat_mask u_mask (
    .i_valid_cols (w_cols),
    .i_beat       (r_beat),
    .i_data       (rd_data),
    .o_data       (w_masked)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start) w_state_nxt = w_start_ok ? A_CMD : DONE;
      A_CMD:    if (cmd_ready) w_state_nxt = A_DATA;
      A_DATA:   if (w_row_end) begin
                  if (w_last_row)    w_state_nxt = B_CMD;
                  else if (w_nxt_ok) w_state_nxt = A_CMD;
                end
      B_CMD:    if (cmd_ready) w_state_nxt = B_DATA;
      B_DATA:   if (w_row_end) begin
                  if (w_last_row)    w_state_nxt = WAIT_ACK;
                  else if (w_nxt_ok) w_state_nxt = B_CMD;
                end
      WAIT_ACK: if (tile_ack)
                  w_state_nxt = (w_kt_wrap && w_nt_wrap && w_mt_wrap) ? DONE : A_CMD;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE) && (r_state != DONE);
    done        = (r_state == DONE);
    cmd_valid   = (r_state == A_CMD) || (r_state == B_CMD);
    cmd_addr    = cmd_valid ? (w_is_a ? w_addr_a : w_addr_b) : '0;
    cmd_len     = cmd_valid ? 8'(BEATS) : 8'd0;
    buf_wr_en   = w_wr;
    buf_sel     = w_wr && (r_state == B_DATA);
    buf_row     = w_wr ? r_row : '0;
    buf_beat    = w_wr ? r_beat : '0;
    buf_data    = (w_wr && w_row_ok) ? w_masked : '0;
    tile_valid  = (r_state == WAIT_ACK);
    tile_last_k = tile_valid && w_kt_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_stride_a <= '0;
      r_stride_b <= '0;
      r_m        <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_mt       <= '0;
      r_nt       <= '0;
      r_kt       <= '0;
      r_row      <= '0;
      r_beat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start && w_start_ok) begin
        r_base_a   <= addr_base_a;
        r_base_b   <= addr_base_b;
        r_stride_a <= stride_a;
        r_stride_b <= stride_b;
        r_m        <= m;
        r_k        <= k;
        r_n        <= n;
        r_mt       <= '0;
        r_nt       <= '0;
        r_kt       <= '0;
        r_row      <= '0;
        r_beat     <= '0;
      end
      if (w_wr) begin
        r_beat <= w_row_end ? '0 : r_beat + BW'(1);
        if (w_row_end) r_row <= w_last_row ? '0 : r_row + RW'(1);
      end
      if (r_state == WAIT_ACK && tile_ack) begin
        r_kt <= w_kt_wrap ? 16'd0 : w_kt_inc[15:0];
        if (w_kt_wrap) begin
          r_nt <= w_nt_wrap ? 16'd0 : w_nt_inc[15:0];
          if (w_nt_wrap) r_mt <= w_mt_wrap ? 16'd0 : w_mt_inc[15:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_tile_load_sequencer.sv
// Scoreboard bench for tile_load_sequencer: stimulus queues expected commands,
// buffer writes, tiles and run totals; a negedge monitor pops and compares.
module tb_tile_load_sequencer;
  import tile_load_pkg::*;

  typedef logic [1+RW+BW+DW-1:0] wr_t;
  typedef struct packed {int cmds; int wrs; int tiles; int done_cyc;} stats_t;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [AW-1:0] addr_base_a = '0, addr_base_b = '0, stride_a = '0, stride_b = '0;
  logic [15:0]   m = '0, k = '0, n = '0;
  logic          busy, done, cmd_valid, cmd_ready, rd_valid;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] rd_data, buf_data;
  logic          buf_wr_en, buf_sel, tile_valid, tile_last_k, tile_ack = 1'b0;
  logic [RW-1:0] buf_row;
  logic [BW-1:0] buf_beat;

  tile_load_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start),
    .addr_base_a(addr_base_a), .addr_base_b(addr_base_b),
    .stride_a(stride_a), .stride_b(stride_b), .m(m), .k(k), .n(n),
    .busy(busy), .done(done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_valid(rd_valid), .rd_data(rd_data),
    .buf_wr_en(buf_wr_en), .buf_sel(buf_sel), .buf_row(buf_row), .buf_beat(buf_beat),
    .buf_data(buf_data), .tile_valid(tile_valid), .tile_last_k(tile_last_k),
    .tile_ack(tile_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] exp_cmd_q[$];
  wr_t           exp_wr_q[$];
  logic          exp_tile_q[$];
  stats_t        exp_stats_q[$];
  int            n_cmp = 0, n_err = 0;
  logic          stall_mode = 1'b0, gap_mode = 1'b0, stray_rv = 1'b0, final_req = 1'b0;

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a, int b);
    logic [DW-1:0] v;
    for (int e = 0; e < EPB; e++) v[e*EW +: EW] = a[15:0] + 16'(b * EPB + e);
    return v;
  endfunction

  function automatic logic [DW-1:0] mask_beat(logic [DW-1:0] d, int cols, int b);
    logic [DW-1:0] v;
    v = '0;
    for (int e = 0; e < EPB; e++) if (b * EPB + e < cols) v[e*EW +: EW] = d[e*EW +: EW];
    return v;
  endfunction

  // DMA model: records accepted commands, returns BEATS beats each in order.
  logic [AW-1:0] pend_q[$];
  int            pend_beat = 0;
  logic          beat_out = 1'b0;
  initial begin
    cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (rstn && cmd_valid && cmd_ready) pend_q.push_back(cmd_addr);
      @(posedge clk); #2;
      if (!rstn) begin
        pend_q.delete(); pend_beat = 0;
      end else if (beat_out && pend_q.size() > 0) begin
        pend_beat++;
        if (pend_beat == BEATS) begin void'(pend_q.pop_front()); pend_beat = 0; end
      end
      cmd_ready = stall_mode ? ((cyc % 12) >= 10) : 1'b1;
      if (rstn && pend_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
        rd_valid = 1'b1; rd_data = pat(pend_q[0], pend_beat); beat_out = 1'b1;
      end else begin
        rd_valid = stray_rv; rd_data = stray_rv ? {DW{1'b1}} : '0; beat_out = 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic          rst_seen = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            run_cmds = 0, run_wrs = 0, run_tiles = 0;
  wr_t           mon_wr;
  stats_t        mon_st;
  always @(posedge clk) rst_seen <= !rstn;

  always @(negedge clk) begin
    if (final_req)
      chk("leftover_expectations",
          {exp_cmd_q.size(), exp_wr_q.size(), exp_tile_q.size(), exp_stats_q.size()}, '0);
    if (rst_seen) begin
      chk("reset_outputs", {busy, done, cmd_valid, cmd_addr, cmd_len, buf_wr_en, buf_sel,
                            buf_row, buf_beat, buf_data, tile_valid, tile_last_k}, '0);
      run_cmds = 0; run_wrs = 0; run_tiles = 0; prev_stall = 1'b0;
    end else if (rstn) begin
      if (prev_stall) chk("cmd_hold_stalled", {cmd_valid, cmd_addr}, {1'b1, prev_addr});
      prev_stall = cmd_valid && !cmd_ready;
      prev_addr  = cmd_addr;
      if (cmd_valid && cmd_ready) begin
        run_cmds++;
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_cmd: got addr %0h expected no command", cmd_addr);
        end else chk("cmd", {cmd_len, cmd_addr}, {8'(BEATS), exp_cmd_q.pop_front()});
      end
      if (buf_wr_en) begin
        run_wrs++;
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: got sel %0d row %0d beat %0d expected no write",
                   buf_sel, buf_row, buf_beat);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          chk("buf_write", {buf_sel, buf_row, buf_beat, buf_data}, mon_wr);
        end
      end
      if (tile_valid && tile_ack) begin
        run_tiles++;
        if (exp_tile_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_tile: got tile_valid expected none");
        end else chk("tile_busy_last_k", {busy, tile_last_k}, {1'b1, exp_tile_q.pop_front()});
      end
      if (done) begin
        if (exp_stats_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          mon_st = exp_stats_q.pop_front();
          chk("done_cycle", cyc, mon_st.done_cyc);
          chk("busy_at_done", busy, 0);
          chk("run_totals", {run_cmds, run_wrs, run_tiles},
              {mon_st.cmds, mon_st.wrs, mon_st.tiles});
        end
        run_cmds = 0; run_wrs = 0; run_tiles = 0;
      end
    end
  end

  task automatic push_run(input int mm, kk, nn, input logic [AW-1:0] ba, bb, sa, sb,
                          output int tiles);
    logic [AW-1:0] a;
    tiles = 0;
    for (int mt = 0; mt < mm; mt += TILE)
      for (int nt = 0; nt < nn; nt += TILE)
        for (int kt = 0; kt < kk; kt += TILE) begin
          for (int r = 0; r < TILE; r++) begin
            a = ba + AW'(mt + r) * sa + AW'(kt * EW / 8);
            if (mt + r < mm) exp_cmd_q.push_back(a);
            for (int b = 0; b < BEATS; b++)
              exp_wr_q.push_back({1'b0, RW'(r), BW'(b),
                                  (mt + r < mm) ? mask_beat(pat(a, b), kk - kt, b) : DW'(0)});
          end
          for (int r = 0; r < TILE; r++) begin
            a = bb + AW'(kt + r) * sb + AW'(nt * EW / 8);
            if (kt + r < kk) exp_cmd_q.push_back(a);
            for (int b = 0; b < BEATS; b++)
              exp_wr_q.push_back({1'b1, RW'(r), BW'(b),
                                  (kt + r < kk) ? mask_beat(pat(a, b), nn - nt, b) : DW'(0)});
          end
          exp_tile_q.push_back(kt + TILE >= kk);
          tiles++;
        end
  endtask

  task automatic launch(input int mm, kk, nn, input logic [AW-1:0] ba, bb, sa, sb);
    @(posedge clk); #1;
    m = 16'(mm); k = 16'(kk); n = 16'(nn);
    addr_base_a = ba; addr_base_b = bb; stride_a = sa; stride_b = sb;
    start = 1'b1;
    @(posedge clk); #1;                    // second start cycle lands outside IDLE
    addr_base_a = 32'hDEAD_0000; stride_a = 32'h0BAD; m = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_run(input int mm, kk, nn, input logic [AW-1:0] ba, bb, sa, sb,
                        input int exp_cmds, exp_wrs, input bit ack_glitch);
    int tiles, w;
    push_run(mm, kk, nn, ba, bb, sa, sb, tiles);
    launch(mm, kk, nn, ba, bb, sa, sb);
    if (ack_glitch) begin
      tile_ack = 1'b1; @(posedge clk); #1; tile_ack = 1'b0;
    end
    for (int t = 0; t < tiles; t++) begin
      w = 0;
      while (!tile_valid) begin
        @(posedge clk); #1; w++;
        if (w > 20000) begin
          $display("FAIL tile_valid_timeout: got no tile after %0d cycles expected tile %0d", w, t);
          $fatal(1);
        end
      end
      if (t == tiles - 1) exp_stats_q.push_back('{exp_cmds, exp_wrs, tiles, cyc + 1});
      tile_ack = 1'b1;
      @(posedge clk); #1;
      tile_ack = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int w;
    #500000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1);
  end

  initial begin
    int w;
    stray_rv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);              // stray rd_valid while idle
    #1 stray_rv = 1'b0;

    do_run(16, 16, 16, 32'h1000, 32'h2000, 32, 32, 32, 64, 1'b1);
    do_run(20, 16, 16, 32'h1000, 32'h2000, 32, 32, 52, 128, 1'b0);
    do_run(16, 20, 16, 32'h1000, 32'h2000, 40, 32, 52, 128, 1'b0);

    stall_mode = 1'b1; gap_mode = 1'b1;
    do_run(16, 16, 16, 32'h1000, 32'h2000, 32, 32, 32, 64, 1'b0);
    stall_mode = 1'b0; gap_mode = 1'b0;

    do_run(3, 5, 18, 32'hFFFF_FFF0, 32'h3000, 16, 64, 16, 128, 1'b0);

    @(posedge clk); #1;
    m = 16'd0; k = 16'd16; n = 16'd16; start = 1'b1;
    exp_stats_q.push_back('{0, 0, 0, cyc + 1});
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);

    begin
      int tiles;
      push_run(16, 16, 16, 32'h1000, 32'h2000, 32, 32, tiles);
    end
    launch(16, 16, 16, 32'h1000, 32'h2000, 32, 32);
    w = 0;
    do begin
      @(negedge clk); w++;
      if (w > 2000) begin
        $display("FAIL reset_target_timeout: got no A row 3 write expected one");
        $fatal(1);
      end
    end while (!(buf_wr_en && !buf_sel && buf_row == RW'(3)));
    @(posedge clk); #1;
    rstn = 1'b0; stray_rv = 1'b1;
    exp_cmd_q.delete(); exp_wr_q.delete(); exp_tile_q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray_rv = 1'b0;
    do_run(16, 16, 16, 32'h1000, 32'h2000, 32, 32, 32, 64, 1'b0);

    @(posedge clk); #1 final_req = 1'b1;
    @(negedge clk); #1 final_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
